// File: rtl/packed_switch_stage.sv
// packed_switch_stage: one Benes column, NUM_LANES/2 2x2 lane switches driven by config bits and a mode override.
// Latency: 1 cycle from accept to out_valid; sustains 1 beat/cycle while out_ready=1.
// Backpressure: output register + skid register; in_ready = !skid_valid & !rst, with no path from out_ready.
// Option: define PKD_SW_CFG_SHADOW_EN to stage cfg writes in a shadow bank copied to active by cfg_commit.
module packed_switch_stage #(
  parameter  int DATA_WIDTH = 512,
  parameter  int NUM_LANES  = 8,
  localparam int NUM_SW     = NUM_LANES / 2,
  localparam int SW_AW      = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [SW_AW-1:0]                cfg_addr,
  input  logic                            cfg_cross,
  input  logic                            cfg_commit,
  input  logic [1:0]                      mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_SW-1:0]               out_cross
);

  logic [NUM_SW-1:0]               r_act;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_out_dat;
  logic [NUM_SW-1:0]               r_out_crs;
  logic                            r_out_vld;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_skd_dat;
  logic [NUM_SW-1:0]               r_skd_crs;
  logic                            r_skd_vld;

  logic [NUM_SW-1:0]               w_eff;
  logic [NUM_LANES*DATA_WIDTH-1:0] w_sw_dat;
  logic                            w_accept;
  logic                            w_emit;

  assign in_ready  = !r_skd_vld && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = r_out_vld && out_ready;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_cross = r_out_crs;

`ifdef PKD_SW_CFG_SHADOW_EN
  logic [NUM_SW-1:0] r_shd;

  // Writes land in the shadow bank; commit copies the pre-write shadow into the active bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shd <= '0;
      r_act <= '0;
    end else begin
      for (int k = 0; k < NUM_SW; k++) begin
        if (cfg_we && ({1'b0, cfg_addr} == (SW_AW+1)'(k))) r_shd[k] <= cfg_cross;
      end
      if (cfg_commit) r_act <= r_shd;
    end
  end
`else
  logic w_unused_commit;
  assign w_unused_commit = cfg_commit;

  // Writes go straight to the active bank; out-of-range addresses match no switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act <= '0;
    end else begin
      for (int k = 0; k < NUM_SW; k++) begin
        if (cfg_we && ({1'b0, cfg_addr} == (SW_AW+1)'(k))) r_act[k] <= cfg_cross;
      end
    end
  end
`endif

  // Effective cross bits: the mode overrides or inverts the configured bits.
  always_comb begin
    w_eff = '0;
    case (mode)
      2'b00:   w_eff = r_act;
      2'b01:   w_eff = '0;
      2'b10:   w_eff = '1;
      default: w_eff = ~r_act;
    endcase
  end

  // Swap lanes 2k and 2k+1 for every switch whose effective bit is set.
  always_comb begin
    w_sw_dat = in_data;
    for (int k = 0; k < NUM_SW; k++) begin
      if (w_eff[k]) begin
        w_sw_dat[(2*k)*DATA_WIDTH +: DATA_WIDTH]   = in_data[(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
        w_sw_dat[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] = in_data[(2*k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output/skid buffer: a new beat goes to the output register when it is free or
  // draining this cycle, otherwise to the skid; an emit refills from the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_crs <= '0;
      r_skd_vld <= 1'b0;
      r_skd_dat <= '0;
      r_skd_crs <= '0;
    end else if (w_accept) begin
      if (!r_out_vld || out_ready) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_sw_dat;
        r_out_crs <= w_eff;
      end else begin
        r_skd_vld <= 1'b1;
        r_skd_dat <= w_sw_dat;
        r_skd_crs <= w_eff;
      end
    end else if (w_emit) begin
      if (r_skd_vld) begin
        r_out_dat <= r_skd_dat;
        r_out_crs <= r_skd_crs;
        r_skd_vld <= 1'b0;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packed_switch_stage.sv
// tb_packed_switch_stage: directed and randomized checks of packed_switch_stage against a lane-permutation model.
// Driver updates inputs on negedge; monitor samples 2 time units later and pops the expected-beat queue on emit.
// Stalled outputs are checked for stability; the run ends with a drain and a summary line.
module tb_packed_switch_stage;

  localparam int DW = 512;
  localparam int NL = 8;
  localparam int NS = NL / 2;
  localparam int AW = 2;

  typedef logic [NL*DW-1:0] dat_t;
  typedef struct packed {
    dat_t          d;
    logic [NS-1:0] c;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic          cfg_cross;
  logic          cfg_commit;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  dat_t          in_data;
  logic          out_valid;
  logic          out_ready;
  dat_t          out_data;
  logic [NS-1:0] out_cross;

  packed_switch_stage #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cross(cfg_cross),
    .cfg_commit(cfg_commit), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cross(out_cross)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit [NS-1:0] m_act = '0;
  bit [NS-1:0] m_shd = '0;
  bit          last_acc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_dat(input string nm, input dat_t act, input dat_t req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      for (int i = 0; i < NL; i++) begin
        if (act[i*DW +: DW] !== req[i*DW +: DW]) begin
          $display("FAIL %s lane %0d: got %h expected %h", nm, i, act[i*DW +: DW], req[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Reference: output lane j takes input lane (j ^ 1) when its switch crosses.
  function automatic beat_t model(input dat_t d, input logic [1:0] md, input bit [NS-1:0] act);
    beat_t b;
    for (int k = 0; k < NS; k++) begin
      case (md)
        2'd0:    b.c[k] = act[k];
        2'd1:    b.c[k] = 1'b0;
        2'd2:    b.c[k] = 1'b1;
        default: b.c[k] = !act[k];
      endcase
    end
    for (int j = 0; j < NL; j++) begin
      int src;
      src = b.c[j/2] ? (j ^ 1) : j;
      b.d[j*DW +: DW] = d[src*DW +: DW];
    end
    return b;
  endfunction

  function automatic dat_t rand_dat();
    dat_t d;
    for (int i = 0; i < NL*DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic dat_t swap_lanes(input dat_t d, input int a, input int b);
    dat_t r;
    r = d;
    r[a*DW +: DW] = d[b*DW +: DW];
    r[b*DW +: DW] = d[a*DW +: DW];
    return r;
  endfunction

  // One clock: inputs are already driven; update the model before the edge, return at next negedge.
  task automatic cyc();
    #1;
    last_acc = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
      m_act = '0;
      m_shd = '0;
    end else begin
      if (last_acc) exp_q.push_back(model(in_data, mode, m_act));
`ifdef PKD_SW_CFG_SHADOW_EN
      if (cfg_commit) m_act = m_shd;
      if (cfg_we && cfg_addr < NS) m_shd[cfg_addr] = cfg_cross;
`else
      if (cfg_we && cfg_addr < NS) m_act[cfg_addr] = cfg_cross;
`endif
    end
    @(negedge clk);
  endtask

  task automatic send(input dat_t d);
    in_valid = 1'b1;
    in_data  = d;
    last_acc = 0;
    for (int n = 0; n < 20 && !last_acc; n++) cyc();
    chk("send_accept_timeout", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int a, input bit x);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_cross = x;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask

  // Monitor: pop on every emit, and require stable outputs across stalls.
  initial begin
    beat_t held;
    beat_t e;
    bit    held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk_dat("stall_data", out_data, held.d);
          chk("stall_cross", 64'(out_cross), 64'(held.c));
        end
        held_v = 0;
        if (out_valid) begin
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk_dat("sb_data", out_data, e.d);
              chk("sb_cross", 64'(out_cross), 64'(e.c));
            end
          end else begin
            held.d = out_data;
            held.c = out_cross;
            held_v = 1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dat_t p, q, e;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_cross = 1'b0; cfg_commit = 1'b0;
    mode = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk_dat("rst_out_data", out_data, '0);
    chk("rst_out_cross", 64'(out_cross), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1: identity pass, one-cycle latency
    for (int i = 0; i < NL; i++) p[i*DW +: DW] = DW'(i);
    send(p);
    chk("t1_latency_valid", 64'(out_valid), 64'd1);
    chk_dat("t1_data", out_data, p);
    chk("t1_cross", 64'(out_cross), 64'd0);
    cyc();

    // 2: switch 1 crosses
    cfg_write(1, 1'b1);
    commit();
    p = rand_dat();
    send(p);
    chk_dat("t2_data", out_data, swap_lanes(p, 2, 3));
    chk("t2_cross", 64'(out_cross), 64'b0010);
    cyc();

    // 3: stall, fill output + skid, third beat held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand_dat(); cyc();
    chk("t3_acc0", 64'(last_acc), 64'd1);
    in_data = rand_dat(); cyc();
    chk("t3_acc1", 64'(last_acc), 64'd1);
    chk("t3_full_in_ready", 64'(in_ready), 64'd0);
    in_data = rand_dat(); cyc();
    chk("t3_acc2_blocked", 64'(last_acc), 64'd0);
    cyc(); cyc();
    out_ready = 1'b1;
    last_acc = 0;
    for (int n = 0; n < 10 && !last_acc; n++) cyc();
    chk("t3_acc2_late", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    repeat (3) cyc();

    // 4: mode overrides with act = 0101
    cfg_write(0, 1'b1); cfg_write(1, 1'b0); cfg_write(2, 1'b1); cfg_write(3, 1'b0);
    commit();
    mode = 2'b10;
    p = rand_dat();
    send(p);
    chk("t4_cross_all", 64'(out_cross), 64'b1111);
    chk_dat("t4_data_all", out_data,
            swap_lanes(swap_lanes(swap_lanes(swap_lanes(p, 0, 1), 2, 3), 4, 5), 6, 7));
    mode = 2'b11;
    p = rand_dat();
    send(p);
    chk("t4_cross_inv", 64'(out_cross), 64'b1010);
    chk_dat("t4_data_inv", out_data, swap_lanes(swap_lanes(p, 2, 3), 6, 7));
    mode = 2'b00;
    cyc();

    // 5: shadow versus direct write
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    cfg_write(0, 1'b1);
    p = rand_dat();
    send(p);
`ifdef PKD_SW_CFG_SHADOW_EN
    chk("t5_before_commit", 64'(out_cross), 64'b0000);
    chk_dat("t5_data_before", out_data, p);
`else
    chk("t5_direct", 64'(out_cross), 64'b0001);
    chk_dat("t5_data_direct", out_data, swap_lanes(p, 0, 1));
`endif
    commit();
    p = rand_dat();
    send(p);
    chk("t5_after_commit", 64'(out_cross), 64'b0001);
    cyc();

    // 6: reset with both registers full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand_dat(); cyc();
    in_data = rand_dat(); cyc();
    in_valid = 1'b0;
    chk("t6_full", 64'(in_ready), 64'd0);
    rst = 1'b1; cyc();
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_cross", 64'(out_cross), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    q = rand_dat();
    send(q);
    chk("t6_first_valid", 64'(out_valid), 64'd1);
    chk_dat("t6_first_data", out_data, q);
    chk("t6_cfg_cleared", 64'(out_cross), 64'd0);
    cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_dat();
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_addr   = AW'($urandom);
      cfg_cross  = 1'($urandom);
      cfg_commit = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 10 && (exp_q.size() != 0 || out_valid); n++) cyc();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
